// File: rtl/key_pkg.sv
// Shared types and width helper for the key conditioning bank.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } key_state_e;

  function automatic int unsigned cnt_w(
    input int unsigned a,
    input int unsigned b
  );
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, debouncer, hold FSM and event pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter int unsigned REPEAT_CYCLES   = 2400000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int unsigned DW = cnt_w(DEBOUNCE_CYCLES, 0);
  localparam int unsigned HW = cnt_w(LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST =
    HW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam logic IDLE_LVL = ACTIVE_LOW;

  logic [1:0]    sync;
  logic          s;
  logic          stable;
  logic [DW-1:0] db_cnt;
  logic          flip;
  logic          rise;
  logic          fall;

  key_state_e    state;
  key_state_e    state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  logic          long_nxt;
  logic          rep_nxt;

  // Synchroniser resets to the released pin level so reset never fakes an edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync <= {2{IDLE_LVL}};
    else          sync <= {sync[0], i_key};
  end

  assign s    = ACTIVE_LOW ? ~sync[1] : sync[1];
  assign flip = (s != stable) && (db_cnt == DB_LAST);
  assign rise = flip & s;
  assign fall = flip & ~s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (s == stable) begin
      db_cnt <= '0;
    end else if (flip) begin
      stable <= s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    long_nxt  = 1'b0;
    rep_nxt   = 1'b0;
    if (fall) begin
      state_nxt = IDLE;
      hold_nxt  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = PRESSED;
            hold_nxt  = '0;
          end
        end
        PRESSED: begin
          if (hold_cnt == LONG_LAST) begin
            long_nxt  = 1'b1;
            hold_nxt  = '0;
            state_nxt = HELD;
          end else begin
            hold_nxt = hold_cnt + HW'(1);
          end
        end
        HELD: begin
          if (REPEAT_CYCLES == 0) begin
            hold_nxt = '0;
          end else if (hold_cnt == REP_LAST) begin
            rep_nxt  = 1'b1;
            hold_nxt = '0;
          end else begin
            hold_nxt = hold_cnt + HW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      o_press   <= rise;
      o_release <= fall;
      o_long    <= long_nxt;
      o_repeat  <= rep_nxt;
    end
  end

  assign o_level = stable;

endmodule

// File: rtl/key_debounce_bank.sv
// N independent key channels plus a combined "any key held" flag.
module key_debounce_bank
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter int unsigned REPEAT_CYCLES   = 2400000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat,
  output logic              o_any_held
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_key     (i_key[g]),
      .o_level   (o_level[g]),
      .o_press   (o_press[g]),
      .o_release (o_release[g]),
      .o_long    (o_long[g]),
      .o_repeat  (o_repeat[g])
    );
  end

  assign o_any_held = |o_level;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Bench for key_debounce_bank: event scoreboard keyed on edge number.
module tb_key_debounce_bank;

  typedef struct {
    int e;
    int kind;
    int ch;
    int dut;
  } ev_t;

  typedef struct {
    int ch;
    int hold;
    int press_e;
    int long_e;
    int rep_first;
    int rep_n;
    int rel_e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] key_a = 4'hf;
  logic [3:0] key_b = 4'hf;

  logic [3:0] lvl_w [2];
  logic [3:0] prs_w [2];
  logic [3:0] rel_w [2];
  logic [3:0] lng_w [2];
  logic [3:0] rep_w [2];
  logic       any_w [2];

  ev_t        sb[$];
  logic [3:0] exp_lvl [2];
  vec_t       vecs [8];
  int         edge_n = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  key_debounce_bank #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20),
    .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b1)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key_a),
    .o_level(lvl_w[0]), .o_press(prs_w[0]),
    .o_release(rel_w[0]), .o_long(lng_w[0]),
    .o_repeat(rep_w[0]), .o_any_held(any_w[0])
  );

  key_debounce_bank #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20),
    .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b1)
  ) u_dut_norep (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key_b),
    .o_level(lvl_w[1]), .o_press(prs_w[1]),
    .o_release(rel_w[1]), .o_long(lng_w[1]),
    .o_repeat(rep_w[1]), .o_any_held(any_w[1])
  );

  task automatic cmp(input string nm, input int d,
                     input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d edge %0d: got %b want %b",
               nm, d, edge_n, got, want);
    end
  endtask

  function automatic void push(input int e, input int k,
                               input int c, input int d);
    sb.push_back('{e, k, c, d});
  endfunction

  task automatic check_zero();
    for (int d = 0; d < 2; d++) begin
      cmp("rst_level", d, lvl_w[d], 4'h0);
      cmp("rst_press", d, prs_w[d], 4'h0);
      cmp("rst_release", d, rel_w[d], 4'h0);
      cmp("rst_long", d, lng_w[d], 4'h0);
      cmp("rst_repeat", d, rep_w[d], 4'h0);
      cmp("rst_any", d, {3'b0, any_w[d]}, 4'h0);
    end
  endtask

  task automatic check_all();
    logic [3:0] ep, er, el, et;
    for (int d = 0; d < 2; d++) begin
      ep = '0; er = '0; el = '0; et = '0;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].e == edge_n && sb[i].dut == d) begin
          case (sb[i].kind)
            0: begin ep[sb[i].ch] = 1'b1; exp_lvl[d][sb[i].ch] = 1'b1; end
            1: begin er[sb[i].ch] = 1'b1; exp_lvl[d][sb[i].ch] = 1'b0; end
            2: el[sb[i].ch] = 1'b1;
            default: et[sb[i].ch] = 1'b1;
          endcase
        end
      end
      cmp("press", d, prs_w[d], ep);
      cmp("release", d, rel_w[d], er);
      cmp("long", d, lng_w[d], el);
      cmp("repeat", d, rep_w[d], et);
      cmp("level", d, lvl_w[d], exp_lvl[d]);
      cmp("any_held", d, {3'b0, any_w[d]}, {3'b0, |exp_lvl[d]});
    end
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].e <= edge_n) sb.delete(i);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    check_all();
  endtask

  task automatic sb_drained(input string nm);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s: got %0d pending events want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    vecs[0] = '{0, 30, 6, 26, 34, 1, 36};
    vecs[1] = '{0, 18, 6, 0, 0, 0, 24};
    vecs[2] = '{1, 3, 0, 0, 0, 0, 0};
    vecs[3] = '{1, 4, 6, 0, 0, 0, 10};
    vecs[4] = '{3, 20, 6, 0, 0, 0, 26};
    vecs[5] = '{3, 21, 6, 26, 0, 0, 27};
    vecs[6] = '{2, 28, 6, 26, 0, 0, 34};
    vecs[7] = '{2, 70, 6, 26, 34, 6, 76};
    exp_lvl[0] = '0;
    exp_lvl[1] = '0;

    // reset asserted mid-cycle with all keys released
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero();
    @(posedge clk);
    #1 rst_n = 1'b1;
    edge_n = 0;
    repeat (50) step();
    sb_drained("reset_idle");

    // table of single-key holds on the repeating instance
    foreach (vecs[v]) begin
      edge_n = 0;
      if (vecs[v].press_e != 0) push(vecs[v].press_e, 0, vecs[v].ch, 0);
      if (vecs[v].long_e != 0) push(vecs[v].long_e, 2, vecs[v].ch, 0);
      for (int k = 0; k < vecs[v].rep_n; k++)
        push(vecs[v].rep_first + 8 * k, 3, vecs[v].ch, 0);
      if (vecs[v].rel_e != 0) push(vecs[v].rel_e, 1, vecs[v].ch, 0);
      key_a[vecs[v].ch] = 1'b0;
      for (int i = 0; i < vecs[v].hold + 16; i++) begin
        step();
        if (edge_n == vecs[v].hold) key_a[vecs[v].ch] = 1'b1;
      end
      sb_drained("vector");
    end

    // bouncing input in 3-cycle segments
    edge_n = 0;
    key_a[1] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      key_a[1] = (((i + 1) / 3) % 2 == 0) ? 1'b0 : 1'b1;
    end
    key_a[1] = 1'b1;
    repeat (10) step();
    sb_drained("bounce");

    // simultaneous press on the no-repeat instance
    edge_n = 0;
    push(6, 0, 0, 1); push(6, 0, 3, 1);
    push(26, 2, 0, 1); push(26, 2, 3, 1);
    push(206, 1, 0, 1); push(206, 1, 3, 1);
    key_b = 4'b0110;
    for (int i = 0; i < 216; i++) begin
      step();
      if (edge_n == 200) key_b = 4'hf;
    end
    sb_drained("simul_norep");

    // reset while key 2 is in HELD
    edge_n = 0;
    push(6, 0, 2, 0); push(26, 2, 2, 0);
    key_a[2] = 1'b0;
    repeat (30) step();
    rst_n = 1'b0;
    #1 check_zero();
    @(posedge clk);
    #1 rst_n = 1'b1;
    edge_n = 0;
    exp_lvl[0] = '0;
    exp_lvl[1] = '0;
    push(6, 0, 2, 0); push(16, 1, 2, 0);
    for (int i = 0; i < 26; i++) begin
      step();
      if (edge_n == 10) key_a[2] = 1'b1;
    end
    sb_drained("reset_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
